// File: rtl/ts4231_config_sequencer_if.sv
// Pin and handshake bundle between the channel sequencer and the shared
// ts4231Configurator core. "master" is the sequencer side, "slave" the core side.
interface ts4231_config_sequencer_if;
   logic reconfigure;
   logic configured;
   logic e_in;
   logic d_in;
   logic e_out;
   logic e_oe;
   logic d_out;
   logic d_oe;

   modport master (
      output reconfigure, e_in, d_in,
      input  configured, e_out, e_oe, d_out, d_oe
   );

   modport slave (
      input  reconfigure, e_in, d_in,
      output configured, e_out, e_oe, d_out, d_oe
   );
endinterface

// File: rtl/ts4231_config_sequencer.sv
// Walks the enabled TS4231 channels in index order, lending the single
// configurator core to one channel at a time with timeout and bounded retries.
module ts4231_config_sequencer #(
   parameter int N_SENSORS      = 4,
   parameter int TIMEOUT_CYCLES = 9_600_000,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int GAP_CYCLES     = 96
) (
   input  logic                 clk_96MHz,
   input  logic                 reset,
   input  logic                 start,
   input  logic [N_SENSORS-1:0] channel_enable,
   input  logic [N_SENSORS-1:0] e_in,
   input  logic [N_SENSORS-1:0] d_in,
   output logic [N_SENSORS-1:0] e_out,
   output logic [N_SENSORS-1:0] e_oe,
   output logic [N_SENSORS-1:0] d_out,
   output logic [N_SENSORS-1:0] d_oe,
   output logic [N_SENSORS-1:0] configured,
   output logic [N_SENSORS-1:0] failed,
   output logic                 busy,
   output logic                 done,
   ts4231_config_sequencer_if.master core
);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int IDX_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

   typedef enum logic [2:0] {IDLE, RUN, SETTLE, NEXT, DONE} state_t;

   state_t               state_q, state_d;
   logic [N_SENSORS-1:0] en_q, en_d;
   logic [IDX_W-1:0]     ch_q, ch_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [ATT_W-1:0]     att_q, att_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 adv_q, adv_d;
   logic [N_SENSORS-1:0] cfg_d, fail_d;
   logic [IDX_W:0]       nxt;
   logic                 run;

   // Lowest set bit of mask at or above index 'from'; MSB of the result flags a hit.
   function automatic logic [IDX_W:0] find_from(input logic [N_SENSORS-1:0] mask,
                                                input int from);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = N_SENSORS - 1; i >= 0; i--) begin
         if (mask[i] && (i >= from)) r = {1'b1, IDX_W'(i)};
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      ch_d    = ch_q;
      tmo_d   = tmo_q;
      att_d   = att_q;
      gap_d   = gap_q;
      adv_d   = adv_q;
      cfg_d   = configured;
      fail_d  = failed;
      nxt     = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               en_d   = channel_enable;
               cfg_d  = '0;
               fail_d = '0;
               tmo_d  = '0;
               att_d  = '0;
               nxt    = find_from(channel_enable, 0);
               // An empty pass still spends one busy cycle in NEXT before DONE.
               if (nxt[IDX_W]) begin
                  ch_d    = nxt[IDX_W-1:0];
                  state_d = RUN;
               end else begin
                  state_d = NEXT;
               end
            end
         end
         RUN: begin
            if (core.configured) begin
               cfg_d[ch_q] = 1'b1;
               adv_d       = 1'b1;
               gap_d       = '0;
               state_d     = SETTLE;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               att_d   = att_q + ATT_W'(1);
               gap_d   = '0;
               state_d = SETTLE;
               if (att_q + ATT_W'(1) == ATT_W'(MAX_ATTEMPTS)) begin
                  fail_d[ch_q] = 1'b1;
                  adv_d        = 1'b1;
               end else begin
                  adv_d = 1'b0;
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         SETTLE: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               tmo_d   = '0;
               state_d = adv_q ? NEXT : RUN;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         NEXT: begin
            nxt   = find_from(en_q, int'(ch_q) + 1);
            tmo_d = '0;
            att_d = '0;
            if (nxt[IDX_W]) begin
               ch_d    = nxt[IDX_W-1:0];
               state_d = RUN;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         state_q    <= IDLE;
         configured <= '0;
         failed     <= '0;
      end else begin
         state_q    <= state_d;
         configured <= cfg_d;
         failed     <= fail_d;
      end
      en_q  <= en_d;
      ch_q  <= ch_d;
      tmo_q <= tmo_d;
      att_q <= att_d;
      gap_q <= gap_d;
      adv_q <= adv_d;
   end

   assign run              = (state_q == RUN);
   assign core.reconfigure = run;
   assign core.e_in        = run & e_in[ch_q];
   assign core.d_in        = run & d_in[ch_q];

   // Only the registered channel index steers the pins, so unselected channels never glitch.
   always_comb begin
      e_out = '0;
      e_oe  = '0;
      d_out = '0;
      d_oe  = '0;
      if (run) begin
         e_out[ch_q] = core.e_out;
         e_oe[ch_q]  = core.e_oe;
         d_out[ch_q] = core.d_out;
         d_oe[ch_q]  = core.d_oe;
      end
   end

   assign busy = (state_q == RUN) || (state_q == SETTLE) || (state_q == NEXT);
   assign done = (state_q == DONE);
endmodule

// File: tb/tb_ts4231_config_sequencer.sv
// Directed bench: a behavioural configurator core plus a per-cycle pin monitor
// that logs every RUN window (channel, length, released gap before it).
module tb_ts4231_config_sequencer;
   localparam int N    = 4;
   localparam int TMO  = 1000;
   localparam int MAXA = 3;
   localparam int GAP  = 96;

   logic         clk_96MHz = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] channel_enable;
   logic [N-1:0] e_in;
   logic [N-1:0] d_in;
   logic [N-1:0] e_out, e_oe, d_out, d_oe;
   logic [N-1:0] configured, failed;
   logic         busy, done;

   ts4231_config_sequencer_if ifc ();

   ts4231_config_sequencer #(
      .N_SENSORS(N), .TIMEOUT_CYCLES(TMO), .MAX_ATTEMPTS(MAXA), .GAP_CYCLES(GAP)
   ) dut (
      .clk_96MHz(clk_96MHz), .reset(reset), .start(start),
      .channel_enable(channel_enable), .e_in(e_in), .d_in(d_in),
      .e_out(e_out), .e_oe(e_oe), .d_out(d_out), .d_oe(d_oe),
      .configured(configured), .failed(failed), .busy(busy), .done(done),
      .core(ifc)
   );

   always #5 clk_96MHz = ~clk_96MHz;

   // Core model: succeeds succ_at cycles into an attempt unless its routed d_in is 1.
   int succ_at = 500;
   int core_cnt = 0;
   always @(posedge clk_96MHz) begin
      if (!ifc.reconfigure) begin
         core_cnt       <= 0;
         ifc.configured <= 1'b0;
         ifc.e_oe       <= 1'b0;
         ifc.d_oe       <= 1'b0;
         ifc.e_out      <= 1'b0;
         ifc.d_out      <= 1'b0;
      end else begin
         core_cnt       <= core_cnt + 1;
         ifc.configured <= !ifc.d_in && (core_cnt + 1 >= succ_at);
         ifc.e_oe       <= 1'b1;
         ifc.d_oe       <= 1'b1;
         ifc.e_out      <= core_cnt[0];
         ifc.d_out      <= ~core_cnt[0];
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0, nwin = 0, in_win = 0, last_end = 0, cur_ch = -1, cur_len = 0;
   int done_cnt = 0, mux_err = 0;
   int w_ch [16];
   int w_len[16];
   int w_gap[16];
   logic [N-1:0] oe_seen;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic sample();
      cyc++;
      if (done) done_cnt++;
      oe_seen = oe_seen | e_oe | d_oe;
      if (ifc.reconfigure) begin
         if (!in_win) begin
            in_win  = 1;
            cur_len = 0;
            cur_ch  = -1;
            if (nwin < 16) w_gap[nwin] = cyc - last_end - 1;
         end
         cur_len++;
         if (e_oe != '0) begin
            if (!$onehot(e_oe) || (cur_ch >= 0 && e_oe != (4'b0001 << cur_ch))) mux_err++;
            for (int i = 0; i < N; i++) if (e_oe[i]) cur_ch = i;
            if (d_oe != e_oe || e_out != (ifc.e_out ? e_oe : 4'b0000) ||
                d_out != (ifc.d_out ? d_oe : 4'b0000)) mux_err++;
         end
         if (cur_ch >= 0 && (ifc.d_in != d_in[cur_ch] || ifc.e_in != e_in[cur_ch])) mux_err++;
      end else begin
         if ((e_oe | d_oe | e_out | d_out) != '0) mux_err++;
         if (in_win) begin
            in_win   = 0;
            last_end = cyc - 1;
            if (nwin < 16) begin
               w_ch[nwin]  = cur_ch;
               w_len[nwin] = cur_len;
            end
            nwin++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_96MHz);
      #2;
      sample();
   endtask

   task automatic clear_log();
      nwin = 0; in_win = 0; done_cnt = 0; mux_err = 0; oe_seen = '0; last_end = cyc;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_busy_at_done"}, busy, 0);
      tick();
      tick();
   endtask

   task automatic begin_pass(input logic [N-1:0] en, input logic [N-1:0] dmask, input int sat);
      clear_log();
      channel_enable = en;
      d_in           = dmask;
      succ_at        = sat;
      start          = 1'b1;
      tick();
      start          = 1'b0;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; channel_enable = '0; d_in = '0; e_in = 4'b1001;
      oe_seen = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_eq("rst_configured", configured, 0);
      check_eq("rst_failed", failed, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_oe", {e_oe, d_oe, e_out, d_out}, 0);
      check_eq("rst_reconf", ifc.reconfigure, 0);

      // All four channels succeed 500 cycles in.
      begin_pass(4'b1111, 4'b0000, 500);
      check_eq("t1_busy", busy, 1);
      check_eq("t1_reconf", ifc.reconfigure, 1);
      wait_done(20000, "t1");
      check_eq("t1_cfg", configured, 4'b1111);
      check_eq("t1_fail", failed, 0);
      check_eq("t1_donecnt", done_cnt, 1);
      check_eq("t1_nwin", nwin, 4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t1_ch%0d", i), w_ch[i], i);
         check_eq($sformatf("t1_len%0d", i), w_len[i], 501);
         if (i > 0) check_eq($sformatf("t1_gap%0d", i), w_gap[i], GAP + 1);
      end
      check_eq("t1_mux", mux_err, 0);

      // Sparse enable; a second start mid-pass with a different mask is ignored.
      begin_pass(4'b1010, 4'b0000, 500);
      check_eq("t2_cfg_cleared", configured, 0);
      repeat (50) tick();
      channel_enable = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(20000, "t2");
      check_eq("t2_cfg", configured, 4'b1010);
      check_eq("t2_fail", failed, 0);
      check_eq("t2_nwin", nwin, 2);
      check_eq("t2_ch0", w_ch[0], 1);
      check_eq("t2_ch1", w_ch[1], 3);
      check_eq("t2_unsel_oe", oe_seen & 4'b0101, 0);
      check_eq("t2_donecnt", done_cnt, 1);
      check_eq("t2_mux", mux_err, 0);

      // Channel 2 never succeeds: three full timeouts, then it is failed.
      begin_pass(4'b1111, 4'b0100, 500);
      wait_done(20000, "t3");
      check_eq("t3_cfg", configured, 4'b1011);
      check_eq("t3_fail", failed, 4'b0100);
      check_eq("t3_nwin", nwin, 6);
      check_eq("t3_ch2a", w_ch[2], 2);
      check_eq("t3_ch2b", w_ch[3], 2);
      check_eq("t3_ch2c", w_ch[4], 2);
      check_eq("t3_ch3", w_ch[5], 3);
      check_eq("t3_len2a", w_len[2], TMO);
      check_eq("t3_len2b", w_len[3], TMO);
      check_eq("t3_len2c", w_len[4], TMO);
      check_eq("t3_len3", w_len[5], 501);
      check_eq("t3_gap_retry1", w_gap[3], GAP);
      check_eq("t3_gap_retry2", w_gap[4], GAP);
      check_eq("t3_gap_adv", w_gap[5], GAP + 1);
      check_eq("t3_mux", mux_err, 0);

      // Success lands on the very last timeout cycle: success wins.
      begin_pass(4'b0001, 4'b0000, TMO - 1);
      n = 0;
      while (ifc.reconfigure && n < 3000) begin
         tick();
         n++;
      end
      check_eq("t4_cfg_next", configured, 4'b0001);
      check_eq("t4_oe_next", e_oe | d_oe, 0);
      check_eq("t4_att", dut.att_q, 0);
      wait_done(5000, "t4");
      check_eq("t4_fail", failed, 0);
      check_eq("t4_len", w_len[0], TMO);
      check_eq("t4_nwin", nwin, 1);

      // One cycle later is a timeout on every attempt.
      begin_pass(4'b0001, 4'b0000, TMO);
      wait_done(8000, "t4b");
      check_eq("t4b_cfg", configured, 0);
      check_eq("t4b_fail", failed, 4'b0001);
      check_eq("t4b_nwin", nwin, 3);

      // Reset while channel 1 is being configured.
      begin_pass(4'b1111, 4'b0000, 500);
      n = 0;
      while (!(nwin == 1 && in_win == 1) && n < 3000) begin
         tick();
         n++;
      end
      repeat (10) tick();
      check_eq("t5_pre_cfg", configured, 4'b0001);
      check_eq("t5_pre_oe", e_oe, 4'b0010);
      reset = 1'b1;
      tick();
      check_eq("t5_oe", {e_oe, d_oe}, 0);
      check_eq("t5_cfg", configured, 0);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_reconf", ifc.reconfigure, 0);
      reset = 1'b0;
      repeat (200) tick();
      check_eq("t5_no_done", done_cnt, 0);
      begin_pass(4'b1111, 4'b0000, 500);
      wait_done(20000, "t5r");
      check_eq("t5r_first_ch", w_ch[0], 0);
      check_eq("t5r_nwin", nwin, 4);
      check_eq("t5r_cfg", configured, 4'b1111);

      // Empty pass, with a further start while it is busy.
      begin_pass(4'b0000, 4'b0000, 500);
      check_eq("t6_busy1", busy, 1);
      check_eq("t6_done1", done, 0);
      check_eq("t6_reconf1", ifc.reconfigure, 0);
      channel_enable = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("t6_done2", done, 1);
      check_eq("t6_busy2", busy, 0);
      tick();
      check_eq("t6_done3", done, 0);
      check_eq("t6_busy3", busy, 0);
      repeat (20) tick();
      check_eq("t6_nwin", nwin, 0);
      check_eq("t6_donecnt", done_cnt, 1);
      check_eq("t6_cfg", configured, 0);
      check_eq("t6_fail", failed, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
